cntr_ctrl: RTL and testbench

Run controller for the team's mod-N up/down counter datapath. The block accepts start/stop/clear commands through a valid/ready port and drives the counter's enable, direction and clear inputs. It runs the counter for a programmed number of ticks, or free-runs it until stopped. It watches the counter value to flag wrap-around, and sits between the test/host sequencer and the counter instance.

---
 rtl/cntr_ctrl.sv | 111 +++++++++++
 tb/tb_cntr_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_ctrl.sv
// Run controller for a mod-N up/down counter: accepts START/STOP/CLEAR commands,
// drives the counter's enable/direction/clear, counts run length and flags wraps.
module cntr_ctrl #(
   parameter int WIDTH  = 4,
   parameter int MAXCNT = 12,
   parameter int LENW   = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [LENW-1:0] cmd_len,
   input  logic [WIDTH-1:0] cnt_q,
   output logic            cnt_en,
   output logic            cnt_up,
   output logic            cnt_clr,
   output logic [LENW-1:0] remain,
   output logic            busy,
   output logic            done,
   output logic            wrap
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_CLR  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [1:0]       OP_START_UP = 2'b00;
   localparam logic [1:0]       OP_STOP     = 2'b10;
   localparam logic [1:0]       OP_CLEAR    = 2'b11;
   localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAXCNT);

   state_t            state_q, state_d;
   logic [LENW-1:0]   remain_q, remain_d;
   logic              up_q, up_d;
   logic              wrap_q, wrap_d;
   logic              accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         up_q     <= 1'b1;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         up_q     <= up_d;
         wrap_q   <= wrap_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      up_d     = up_q;
      accept   = cmd_valid & cmd_ready;
      // Out-of-range counter values never match either terminal, so no wrap is raised.
      wrap_d   = (state_q == ST_RUN) && (up_q ? (cnt_q == MAX_V) : (cnt_q == '0));

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!cmd_op[1]) begin
                  state_d  = ST_RUN;
                  remain_d = cmd_len;
                  up_d     = (cmd_op == OP_START_UP);
               end else if (cmd_op == OP_CLEAR) begin
                  state_d = ST_CLR;
               end
            end
         end
         ST_RUN: begin
            // An accepted command always wins over length expiry.
            if (accept) begin
               if (!cmd_op[1]) begin
                  remain_d = cmd_len;
                  up_d     = (cmd_op == OP_START_UP);
               end else if (cmd_op == OP_STOP) begin
                  state_d  = ST_IDLE;
                  remain_d = '0;
               end else begin
                  state_d  = ST_CLR;
                  remain_d = '0;
               end
            end else if (remain_q == LENW'(1)) begin
               state_d  = ST_DONE;
               remain_d = '0;
            end else if (remain_q > LENW'(1)) begin
               remain_d = remain_q - LENW'(1);
            end
         end
         ST_CLR:  state_d = ST_IDLE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign cnt_en    = (state_q == ST_RUN);
   assign cnt_clr   = (state_q == ST_CLR);
   assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign cnt_up    = up_q;
   assign remain    = remain_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_cntr_ctrl.sv
// Self-checking bench for cntr_ctrl: a behavioural counter datapath closes the loop,
// and a run-level reference model predicts every output each cycle.
module tb_cntr_ctrl;

   localparam int WIDTH  = 4;
   localparam int MAXCNT = 12;
   localparam int LENW   = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [1:0]      cmd_op = 2'b00;
   logic [LENW-1:0] cmd_len = '0;
   logic [WIDTH-1:0] cnt_fed;
   logic            cnt_en, cnt_up, cnt_clr, busy, done, wrap;
   logic [LENW-1:0] remain;

   // counter datapath plus host preload and an override for illegal values
   logic [WIDTH-1:0] ctr = '0;
   logic             ld_en = 1'b0;
   logic [WIDTH-1:0] ld_val = '0;
   logic             ill_en = 1'b0;
   logic [WIDTH-1:0] ill_val = '0;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: run-level view of the controller
   bit m_run, m_done, m_clr, m_up, m_wrap;
   int m_left, m_cnt;

   cntr_ctrl #(.WIDTH(WIDTH), .MAXCNT(MAXCNT), .LENW(LENW)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
      .cnt_q(cnt_fed), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
      .remain(remain), .busy(busy), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   assign cnt_fed = ill_en ? ill_val : ctr;

   always_ff @(posedge clk) begin
      if (ld_en)        ctr <= ld_val;
      else if (cnt_clr) ctr <= '0;
      else if (cnt_en)  ctr <= cnt_up ? ((ctr == WIDTH'(MAXCNT)) ? '0 : ctr + 1'b1)
                                       : ((ctr == '0) ? WIDTH'(MAXCNT) : ctr - 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_clr = 0; m_up = 1; m_wrap = 0; m_left = 0;
   endtask

   task automatic model_step();
      int  fed;
      bit  acc;
      fed    = ill_en ? int'(ill_val) : m_cnt;
      acc    = cmd_valid && !(m_clr || m_done);
      m_wrap = m_run && (m_up ? (fed == MAXCNT) : (fed == 0));
      if (ld_en)      m_cnt = int'(ld_val);
      else if (m_clr) m_cnt = 0;
      else if (m_run) m_cnt = m_up ? (m_cnt + 1) % (MAXCNT + 1) : (m_cnt + MAXCNT) % (MAXCNT + 1);
      m_done = 0;
      m_clr  = 0;
      if (acc) begin
         case (cmd_op)
            2'd0, 2'd1: begin m_run = 1; m_left = int'(cmd_len); m_up = (cmd_op == 2'd0); end
            2'd2:       begin m_run = 0; m_left = 0; end
            default:    begin m_run = 0; m_left = 0; m_clr = 1; end
         endcase
      end else if (m_run && m_left > 0) begin
         m_left--;
         if (m_left == 0) begin m_run = 0; m_done = 1; end
      end
   endtask

   task automatic check_all();
      check("cnt_en", cnt_en, m_run);
      check("cnt_up", cnt_up, m_up);
      check("cnt_clr", cnt_clr, m_clr);
      check("remain", remain, m_left);
      check("busy", busy, m_run || m_clr || m_done);
      check("done", done, m_done);
      check("wrap", wrap, m_wrap);
      check("cmd_ready", cmd_ready, !(m_clr || m_done));
      check("cnt_q", ctr, m_cnt);
   endtask

   int done_cnt, busy_cnt, wrap_cnt;

   task automatic tick(input bit v, input logic [1:0] op, input int len);
      cmd_valid = v; cmd_op = op; cmd_len = LENW'(len);
      @(posedge clk);
      if (reset) model_step(); else model_reset();
      @(negedge clk);
      check_all();
      done_cnt += int'(done);
      busy_cnt += int'(busy);
      wrap_cnt += int'(wrap);
      $display("[TB] t=%0t v=%0d op=%0d len=%0d q=%0d en=%0d up=%0d clr=%0d rem=%0d busy=%0d done=%0d wrap=%0d",
               $time, v, op, len, ctr, cnt_en, cnt_up, cnt_clr, remain, busy, done, wrap);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 2'd0, 0);
   endtask

   task automatic preload(input int val);
      ld_en = 1'b1; ld_val = WIDTH'(val);
      tick(0, 2'd0, 0);
      ld_en = 1'b0;
   endtask

   task automatic clr_counts();
      done_cnt = 0; busy_cnt = 0; wrap_cnt = 0;
   endtask

   initial begin
      model_reset();
      m_cnt = 0;
      repeat (3) @(negedge clk);
      check_all();
      reset = 1'b1;

      // counted up run of 5 from 0
      preload(0);
      clr_counts();
      tick(1, 2'd0, 5);
      idle(6);
      check("s1_q", ctr, 5);
      check("s1_done", done_cnt, 1);
      check("s1_busy", busy_cnt, 6);

      // free-run up from 10 through the wrap, then STOP at q=1
      preload(10);
      clr_counts();
      tick(1, 2'd0, 0);
      idle(4);
      check("s2_q_before_stop", ctr, 1);
      tick(1, 2'd2, 0);
      idle(3);
      check("s2_q", ctr, 2);
      check("s2_wrap", wrap_cnt, 1);
      check("s2_done", done_cnt, 0);

      // counted down run of 3 from 1
      preload(1);
      clr_counts();
      tick(1, 2'd1, 3);
      idle(5);
      check("s3_q", ctr, 11);
      check("s3_wrap", wrap_cnt, 1);
      check("s3_done", done_cnt, 1);
      check("s3_up", cnt_up, 0);

      // STOP on the last tick suppresses done; START in RUN reloads remain
      preload(0);
      clr_counts();
      tick(1, 2'd0, 4);
      idle(3);
      check("s4_rem1", remain, 1);
      tick(1, 2'd2, 0);
      idle(3);
      check("s4_done", done_cnt, 0);
      check("s4_busy", busy, 0);
      tick(1, 2'd0, 4);
      idle(1);
      tick(1, 2'd0, 2);
      check("s4_reload", remain, 2);
      idle(4);

      // CLEAR in RUN at q=7
      preload(7);
      tick(1, 2'd0, 0);
      tick(1, 2'd3, 0);
      check("s5_q_step", ctr, 8);
      check("s5_clr", cnt_clr, 1);
      idle(1);
      check("s5_q_clr", ctr, 0);
      check("s5_ready", cmd_ready, 1);

      // asynchronous reset mid-run, then a single-tick run
      tick(1, 2'd0, 20);
      idle(3);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("s6_en_async", cnt_en, 0);
      check("s6_busy_async", busy, 0);
      check("s6_rem_async", remain, 0);
      idle(2);
      reset = 1'b1;
      preload(3);
      clr_counts();
      tick(1, 2'd0, 1);
      idle(3);
      check("s6_q", ctr, 4);
      check("s6_done", done_cnt, 1);

      // illegal counter values never raise wrap
      preload(12);
      clr_counts();
      ill_en = 1'b1; ill_val = 4'd15;
      tick(1, 2'd0, 0);
      idle(3);
      tick(1, 2'd1, 0);
      idle(3);
      tick(1, 2'd2, 0);
      idle(1);
      ill_en = 1'b0;
      check("ill_wrap", wrap_cnt, 0);

      // randomized command traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0)
            tick(1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
         else
            tick(0, 2'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
